// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states,
// opcodes, ALU and PC-source selects, plus the control-word struct.
package mips_mc_ctrl_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_BEQ = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  // One cycle's worth of control outputs
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       pc_en;
    logic       ir_en;
    logic       ab_en;
    logic       aluout_en;
    logic       mdr_en;
    logic       rf_we;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       alu_src_b;
    logic       wb_sel;
  } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts stalled request cycles and flags the cycle
// whose stall would bring the count up to TIMEOUT.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  logic [7:0] cnt;
  logic [7:0] cnt_inc;

  assign cnt_inc = cnt + 8'd1;
  // inc is already gated by !mem_ready, so a completing access never times out
  assign timeout = inc && (cnt_inc == 8'(TIMEOUT));

  // Wait count: cleared on every FSM transition, stepped on stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt_inc;
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control FSM for the 8-bit MIPS core. Mealy outputs drive the
// datapath load enables; memory accesses are timed out via mem_wait_timer.
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             pc_en,
  output logic             ir_en,
  output logic             ab_en,
  output logic             aluout_en,
  output logic             mdr_en,
  output logic             rf_we,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src_b,
  output logic             wb_sel,
  output logic             err,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state
);

  logic [2:0]       state_q, state_d, next_fetch;
  logic             err_q, set_err, retire, tmo, in_access, clr_wait, inc_wait;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t            c;

  // After retiring, dropping run parks the FSM in IDLE instead of fetching
  assign next_fetch = run ? S_FETCH : S_IDLE;
  assign in_access  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign inc_wait   = in_access && !mem_ready;
  assign clr_wait   = (state_d != state_q);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk     (clk),
    .rst     (reset),
    .clr     (clr_wait),
    .inc     (inc_wait),
    .timeout (tmo)
  );

  // Next-state and Mealy output decode
  always_comb begin
    c       = '0;
    state_d = state_q;
    retire  = 1'b0;
    set_err = 1'b0;
    case (state_q)
      S_IDLE: if (run && !err_q) state_d = S_FETCH;
      S_FETCH: begin
        c.mem_req = 1'b1;
        if (mem_ready) begin
          c.ir_en  = 1'b1;
          c.pc_en  = 1'b1;
          c.pc_src = PC_INC;
          state_d  = S_DECODE;
        end else if (tmo) begin
          set_err = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        c.ab_en = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_LW, OP_SW: begin
            c.alu_op    = ALU_ADD;
            c.alu_src_b = 1'b1;
            c.aluout_en = 1'b1;
            state_d     = S_MEM;
          end
          OP_BEQ: begin
            c.alu_op = ALU_SUB;
            c.pc_en  = zero;
            c.pc_src = PC_BR;
            retire   = 1'b1;
            state_d  = next_fetch;
          end
          OP_JMP: begin
            c.pc_en  = 1'b1;
            c.pc_src = PC_JMP;
            retire   = 1'b1;
            state_d  = next_fetch;
          end
          default: begin
            c.alu_op    = opcode[1:0];
            c.aluout_en = 1'b1;
            state_d     = S_WB;
          end
        endcase
      end
      S_MEM: begin
        c.mem_req = 1'b1;
        c.mem_we  = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            retire  = 1'b1;
            state_d = next_fetch;
          end else begin
            c.mdr_en = 1'b1;
            state_d  = S_WB;
          end
        end else if (tmo) begin
          set_err = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        c.rf_we  = 1'b1;
        c.wb_sel = (opcode == OP_LW);
        retire   = 1'b1;
        state_d  = next_fetch;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Sticky timeout flag; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err_q <= 1'b0;
    else if (set_err) err_q <= 1'b1;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign mem_req     = c.mem_req;
  assign mem_we      = c.mem_we;
  assign pc_en       = c.pc_en;
  assign ir_en       = c.ir_en;
  assign ab_en       = c.ab_en;
  assign aluout_en   = c.aluout_en;
  assign mdr_en      = c.mdr_en;
  assign rf_we       = c.rf_we;
  assign pc_src      = c.pc_src;
  assign alu_op      = c.alu_op;
  assign alu_src_b   = c.alu_src_b;
  assign wb_sel      = c.wb_sel;
  assign err         = err_q;
  assign instr_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: each queued instruction expands into
// the control events it must produce (cycle, state, enables, selects,
// retire count); a monitor pops and compares them as the DUT emits them.
`timescale 1ns/1ps
module tb_mips_mc_ctrl;
  import mips_mc_ctrl_pkg::*;

  localparam int TMO = 15;
  localparam int CW  = 4;

  logic          clk = 1'b0, reset = 1'b0, run = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [2:0]    opcode = 3'b000;
  logic          mem_req, mem_we, pc_en, ir_en, ab_en, aluout_en, mdr_en, rf_we;
  logic [1:0]    pc_src, alu_op;
  logic          alu_src_b, wb_sel, err;
  logic [CW-1:0] instr_count;
  logic [2:0]    state;

  mips_mc_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .pc_en(pc_en),
    .ir_en(ir_en), .ab_en(ab_en), .aluout_en(aluout_en), .mdr_en(mdr_en),
    .rf_we(rf_we), .pc_src(pc_src), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .wb_sel(wb_sel), .err(err), .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0]  en_v;
  logic [14:0] outs;
  assign en_v = {pc_en, ir_en, ab_en, aluout_en, mdr_en, rf_we};
  assign outs = {mem_req, mem_we, en_v, pc_src, alu_op, alu_src_b, wb_sel, err};

  typedef struct { int cyc; logic [15:0] val; logic [15:0] msk; logic [CW-1:0] cnt; } ev_t;
  typedef struct { int w; bit fetch; logic [2:0] op; logic z; } acc_t;

  ev_t  evq[$];
  acc_t accq[$];
  int   n_cmp = 0, n_bad = 0;
  int   tcur = 0;
  logic [CW-1:0] cnt_m = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // m = {pc_src, alu_op, alu_src_b, wb_sel, mem_we} compare enables
  task automatic push_ev(input int c, input logic [2:0] st, input logic [5:0] en,
                         input logic [1:0] pcs, input logic [1:0] alu, input logic sb,
                         input logic wb, input logic we, input logic [4:0] m);
    ev_t e;
    e.cyc = c;
    e.val = {st, en, pcs, alu, sb, wb, we};
    e.msk = {9'h1ff, {2{m[4]}}, {2{m[3]}}, m[2], m[1], m[0]};
    e.cnt = cnt_m;
    evq.push_back(e);
  endtask

  // Reference model: instruction -> expected event schedule from tcur
  task automatic add_instr(input logic [2:0] op, input logic z, input int fw, input int mw);
    acc_t a;
    int   t;
    a.w = fw; a.fetch = 1'b1; a.op = op; a.z = z;
    accq.push_back(a);
    t = tcur + fw;
    push_ev(t,   S_FETCH,  6'b110000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'b10001);
    push_ev(t+1, S_DECODE, 6'b001000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'b00000);
    t = t + 2;
    if (op == OP_BEQ) begin
      push_ev(t, S_EXEC, {z, 5'b00000}, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 5'b11000);
      tcur = t + 1;
    end else if (op == OP_JMP) begin
      push_ev(t, S_EXEC, 6'b100000, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 5'b10000);
      tcur = t + 1;
    end else if (op == OP_LW || op == OP_SW) begin
      push_ev(t, S_EXEC, 6'b000100, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 5'b01100);
      a.w = mw; a.fetch = 1'b0;
      accq.push_back(a);
      if (op == OP_LW) begin
        push_ev(t+1+mw, S_MEM, 6'b000010, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'b00001);
        push_ev(t+2+mw, S_WB,  6'b000001, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 5'b00010);
        tcur = t + 3 + mw;
      end else begin
        push_ev(t+1+mw, S_MEM, 6'b000000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 5'b00001);
        tcur = t + 2 + mw;
      end
    end else begin
      push_ev(t,   S_EXEC, 6'b000100, 2'b00, op[1:0], 1'b0, 1'b0, 1'b0, 5'b01100);
      push_ev(t+1, S_WB,   6'b000001, 2'b00, 2'b00,   1'b0, 1'b0, 1'b0, 5'b00010);
      tcur = t + 2;
    end
    cnt_m = cnt_m + 1'b1;
  endtask

  // Memory responder: each access answers after its queued wait count;
  // a completed fetch presents the new IR contents to the FSM.
  initial begin
    acc_t cur;
    int   wc;
    bit   act;
    act = 1'b0; wc = 0;
    cur.w = 1000; cur.fetch = 1'b0; cur.op = 3'b000; cur.z = 1'b0;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        mem_ready = 1'b0;
        act = 1'b0;
      end else begin
        if (!act) begin
          act = 1'b1;
          wc  = 0;
          if (accq.size() > 0) cur = accq.pop_front();
          else begin cur.w = 1000; cur.fetch = 1'b0; end
        end
        mem_ready = (wc == cur.w);
        wc++;
        if (mem_ready) begin
          act = 1'b0;
          if (cur.fetch) begin opcode = cur.op; zero = cur.z; end
        end
      end
    end
  end

  // Monitor: any enable, a memory handshake, or EXEC/WB is an event
  initial begin
    logic [15:0] a;
    ev_t e;
    forever begin
      @(negedge clk); #1;
      if (!reset && (en_v != 6'b0 || (mem_req && mem_ready) || state == S_EXEC || state == S_WB)) begin
        a = {state, en_v, pc_src, alu_op, alu_src_b, wb_sel, mem_we};
        n_cmp++;
        if (evq.size() == 0) begin
          n_bad++;
          $display("FAIL event: unexpected at cycle %0d got %h cnt %0d", cyc, a, instr_count);
        end else begin
          e = evq.pop_front();
          if (cyc != e.cyc || ((a ^ e.val) & e.msk) != 16'h0 || instr_count !== e.cnt) begin
            n_bad++;
            $display("FAIL event: got cyc %0d val %h cnt %0d, expected cyc %0d val %h mask %h cnt %0d",
                     cyc, a, instr_count, e.cyc, e.val, e.msk, e.cnt);
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; run = 1'b0;
    repeat (2) @(negedge clk);
    evq.delete(); accq.delete(); cnt_m = '0;
    reset = 1'b0;
  endtask

  task automatic start();
    @(negedge clk);
    tcur = cyc + 1;
  endtask

  // Drop run once only the last retire event is pending, then drain
  task automatic finish_prog(input int budget);
    int k;
    k = 0;
    while (evq.size() > 1 && k < budget) begin @(negedge clk); #2; k++; end
    run = 1'b0;
    while (evq.size() > 0 && k < budget) begin @(negedge clk); #2; k++; end
    chk("drain", evq.size(), 0);
    evq.delete();
    repeat (2) @(negedge clk);
    #2;
    chk("end_state", state, S_IDLE);
    chk("end_cnt", instr_count, cnt_m);
    chk("end_req", mem_req, 1'b0);
  endtask

  initial begin
    int k, t_idle, fw, mw;
    logic [2:0] op;
    #1 reset = 1'b1;
    #1;
    chk("rst_outs", outs, 15'h0);
    chk("rst_cnt", instr_count, 0);
    chk("rst_state", state, S_IDLE);
    do_reset();

    // Directed opener then randomized program
    start();
    add_instr(OP_ADD, 1'b0, 0, 0);
    add_instr(OP_LW,  1'b0, 2, 2);
    add_instr(OP_BEQ, 1'b0, 0, 0);
    add_instr(OP_BEQ, 1'b1, 1, 0);
    add_instr(OP_JMP, 1'b0, 0, 0);
    add_instr(OP_SW,  1'b0, 0, 1);
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      fw = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
      add_instr(op, 1'($urandom_range(0, 1)), fw, mw);
    end
    add_instr(OP_ADD, 1'b0, 0, 0);
    run = 1'b1;
    finish_prog(4000);
    chk("rand_err", err, 1'b0);

    // Ready on the timeout cycle completes; 16 retires wrap the counter
    do_reset();
    start();
    add_instr(OP_LW, 1'b0, 14, 14);
    for (int i = 0; i < 15; i++) add_instr(OP_JMP, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 0);
    run = 1'b1;
    finish_prog(2000);
    chk("wrap_cnt", instr_count, 0);
    chk("bound_err", err, 1'b0);

    // Memory never answers in MEM: timeout after 15 wait cycles
    do_reset();
    start();
    t_idle = tcur + 18;
    add_instr(OP_LW, 1'b0, 0, 100);
    run = 1'b1;
    while (cyc < t_idle - 1) @(negedge clk);
    #2;
    chk("tmo_pre_state", state, S_MEM);
    chk("tmo_pre_req", mem_req, 1'b1);
    chk("tmo_pre_err", err, 1'b0);
    @(negedge clk); #2;
    chk("tmo_err", err, 1'b1);
    chk("tmo_state", state, S_IDLE);
    chk("tmo_outs", outs, 15'h1);
    repeat (5) @(negedge clk);
    #2;
    chk("tmo_norestart", {state, mem_req}, {S_IDLE, 1'b0});
    chk("tmo_left", evq.size(), 2);
    do_reset();
    #1;
    chk("tmo_clr", err, 1'b0);

    // Asynchronous reset in the middle of an SW memory access
    start();
    add_instr(OP_SW, 1'b0, 1, 100);
    run = 1'b1;
    k = 0;
    while (state != S_MEM && k < 50) begin @(negedge clk); #2; k++; end
    chk("sw_in_mem", state, S_MEM);
    repeat (2) @(negedge clk);
    #2;
    chk("sw_req", {mem_req, mem_we}, 2'b11);
    #1 reset = 1'b1;
    #1;
    chk("arst_req", {mem_req, mem_we}, 2'b00);
    chk("arst_outs", outs, 15'h0);
    chk("arst_state", state, S_IDLE);
    chk("arst_left", evq.size(), 1);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control FSM for the 8-bit MIPS core. Sequences fetch, decode, execute, memory and write-back by driving the load enables of the core's state registers (PC, IR, A/B, ALU-out, MDR) and the register-file write enable. Handshakes with a variable-latency memory port, enforces a timeout on that port, and counts retired instructions. Sits beside the datapath; owns no datapath registers itself.

## Interface
- TIMEOUT, 15: maximum wait cycles for mem_ready per access (1..255).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all state.
- run  in  1  start/continue execution; sampled in IDLE only.
- opcode  in  3  IR[7:5] from the datapath IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completion.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, valid with mem_req.
- pc_en, ir_en, ab_en, aluout_en, mdr_en, rf_we  out  1 each  register load enables.
- pc_src  out  2  00 = PC+1, 01 = branch target, 10 = jump target.
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- alu_src_b  out  1  0 = B, 1 = sign-extended immediate.
- wb_sel  out  1  0 = ALU-out, 1 = MDR.
- err  out  1  sticky memory-timeout flag.
- instr_count  out  CNT_W  retired instructions.
- state  out  3  current state, for debug.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 LW, 101 SW, 110 BEQ, 111 JMP.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE: all outputs 0; run=1 and err=0 -> FETCH.
- FETCH: mem_req=1, mem_we=0. On mem_ready: ir_en=1, pc_en=1, pc_src=00 -> DECODE.
- DECODE: ab_en=1 -> EXEC.
- EXEC, R-type (0xx): alu_op=opcode[1:0], alu_src_b=0, aluout_en=1 -> WB.
- EXEC, LW/SW: alu_op=00, alu_src_b=1, aluout_en=1 -> MEM.
- EXEC, BEQ: alu_op=01; pc_en=zero, pc_src=01 -> FETCH; retires.
- EXEC, JMP: pc_en=1, pc_src=10 -> FETCH; retires.
- MEM: mem_req=1, mem_we=(SW). On mem_ready: LW -> mdr_en=1 -> WB; SW -> FETCH, retires.
- WB: rf_we=1, wb_sel=(LW) -> FETCH; retires.
- Retire: instr_count increments by 1 on the transition out; wraps from all-ones to 0.
- Timeout: a wait counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 and mem_ready=0. When it reaches TIMEOUT, set err=1, drop mem_req, -> IDLE with no enables asserted. err clears only on reset; IDLE does not restart while err=1.
- mem_ready outside FETCH/MEM is ignored.

## Timing
- Outputs are combinational from the state register plus opcode/zero/mem_ready (Mealy); enables take effect at the next posedge.
- Reset values: state=IDLE, every output 0, instr_count=0, err=0, wait counter 0.
- mem_req stays high continuously from state entry until the cycle mem_ready=1. Completion occurs on the edge where both are high.
- Cycle counts with zero-wait memory: BEQ/JMP 3 cycles, SW 4, R-type 4, LW 5. Each wait cycle adds 1.
- mem_ready=1 on the same cycle the wait counter hits TIMEOUT: the access completes, no error.
- Reset asserted mid-access drops mem_req immediately (asynchronous). No enable pulses occur.
- run dropped mid-instruction has no effect until the FSM returns to FETCH. At FETCH entry run=0 -> IDLE instead.

## Structure
- Shared header mips_ctrl_defs.vh holds state encodings, opcode constants, alu_op and pc_src encodings; the datapath includes the same file.
- One sub-module, mem_wait_timer: wait counter with a TIMEOUT compare and a timeout output.
- FSM, output decode, and the retire counter stay in mips_mc_ctrl.

## Test plan
- Reset then run=1, ADD (000), mem_ready every cycle -> states IDLE, FETCH, DECODE, EXEC, WB, FETCH; rf_we pulses once with wb_sel=0; instr_count=1.
- LW with 2 wait cycles in FETCH and MEM -> LW takes 9 cycles; mdr_en pulses exactly once; WB has wb_sel=1.
- BEQ with zero=0, then zero=1 -> first: no pc_en in EXEC; second: pc_en=1 with pc_src=01.
- mem_ready held low in MEM with TIMEOUT=15 -> after 15 wait cycles err=1, mem_req=0, state IDLE; run=1 does not restart; reset clears err.
- Preload instr_count to all-ones, then run one JMP -> instr_count=0; pc_src=10.
- Assert reset mid-MEM of an SW -> mem_req and mem_we drop asynchronously; all outputs 0; state IDLE.
